mtm_alu_serializer: RTL and testbench
=====================================

# mtm_alu_serializer

Output-side serial transmitter for the MTM ALU link. It accepts one completed result (32-bit C plus flags) or one error report through a valid/ready handshake. It encodes the result into the ALU's framed serial format and drives it bit-serially on `sout`. It is the transmit counterpart of the `sout` decoder used by the scoreboard, and sits between the ALU core and the output pin.

## Interface
Parameters:
- `BYTE_BITS`, 8: payload bits per frame.
- `DATA_BYTES`, 4: number of data frames in a normal response.

Ports:
- `clk`  in  1  single design clock; one serial bit per cycle.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `res_valid`  in  1  result present on `C`/`flags`/`err`/`err_flags`.
- `res_ready`  out  1  serializer can accept a result this cycle.
- `C`  in  32  ALU result.
- `flags`  in  4  {Carry, Overflow, Zero, Negative}.
- `err`  in  1  1 = send an error response instead of data.
- `err_flags`  in  6  error field, transmitted unmodified.
- `sout`  out  1  serial output; idles high.
- `busy`  out  1  high while a response is on the line.

## Operation
- Frame is 11 bits, MSB first:
  - start bit 0;
  - type bit: 0 = DATA, 1 = CTL;
  - 8 payload bits, b7 first;
  - stop bit 1.
- Normal response (`err`=0) is 5 frames:
  - 4 DATA frames: C[31:24], C[23:16], C[15:8], C[7:0];
  - then 1 CTL frame with payload {1'b0, flags[3:0], crc[2:0]}.
- CRC:
  - crc = CRC-3, polynomial x^3+x+1, initial value 0;
  - computed over the 37 bits {C[31:0], 1'b0, flags[3:0]}, MSB first.
- Error response (`err`=1) is a single CTL frame with payload {1'b1, err_flags[5:0], parity}.
  - parity makes the number of ones in the 8-bit payload even.
- Handshake:
  - transfer occurs on a posedge where `res_valid`=1 and `res_ready`=1;
  - all inputs are captured into internal registers at that edge;
  - input changes afterwards have no effect.
- FSM states: IDLE, SEND, GAP (GAP exists only when the macro is defined).
  - IDLE: `res_ready`=1, `sout`=1, `busy`=0. On transfer, go to SEND with byte_cnt=0 and bit_cnt=0.
  - SEND: `sout` is the frame bit selected by bit_cnt (0..10).
    - When bit_cnt=10 and this is the last frame, go to IDLE.
    - When bit_cnt=10 and frames remain: byte_cnt++, bit_cnt=0, or go to GAP if the macro is defined.
  - GAP: `sout`=1 for one cycle, then back to SEND.
- Frame count is 5 for a normal response and 1 for an error response; byte_cnt is 3 bits wide.
- `res_ready`=0 in SEND and GAP. `res_valid` asserted in those states is held off and never dropped.
- Reset values: `sout`=1, `res_ready`=1, `busy`=0, state IDLE, counters 0, captured registers 0.

## Timing
- Transfer at edge T: the start bit appears on `sout` in cycle T+1, registered output.
- Normal response, no gap: bits occupy cycles T+1..T+55; IDLE and `res_ready`=1 from cycle T+56.
- Error response: cycles T+1..T+11; IDLE from cycle T+12.
- Back-to-back transfers are separated by exactly one idle-high cycle. Transfer at T+56 puts the next start bit at T+57.
- With the gap enabled, one extra high cycle follows each non-final frame: normal response spans 59 cycles.
- `busy`=1 exactly on cycles carrying frame or gap bits.
- Reset asserted mid-response: `sout`=1 and `res_ready`=1 immediately (asynchronously). The partial frame is abandoned and nothing is resumed after release.
- `res_valid` with X inputs while not ready is ignored.

## Configuration
- Macro: `MTM_ALU_SER_IDLE_GAP_EN`.
- Defined: GAP state is present; one idle-high bit is inserted between consecutive frames of one response.
- Undefined: frames within a response are contiguous; the GAP state and its logic are absent.

## Structure
- `mtm_alu_pkg` holds:
  - frame type constants: FRAME_DATA = 1'b0, FRAME_CTL = 1'b1;
  - frame length constant (11);
  - the state enum `ser_state_t`;
  - a CRC-3 function shared with the checking models.
- Sub-module `mtm_alu_crc3` is combinational and computes CRC-3 over 37 bits. It is instantiated once; its output is registered at transfer.

## Test plan
- Reset then idle 20 cycles -> `sout`=1, `res_ready`=1, `busy`=0 throughout.
- C=0x00000001, flags=4'b0000, err=0 -> frames 0_0_00000000_1 ×3, then 0_0_00000001_1, then CTL 0_1_{0,0000,crc}_1. crc equals the package function; `res_ready` returns high 56 cycles after the transfer.
- err=1, err_flags=6'b100100 -> a single frame 0_1_11001001_1 (payload 0xC9); `res_ready` high 12 cycles after the transfer.
- Two results presented back-to-back with `res_valid` held high -> second transfer at T+56 and exactly one high cycle between the stop and start bits.
- Reset pulse at bit 20 of a normal response -> `sout`=1 asynchronously; after release a new result serializes correctly from its first frame.
- With `MTM_ALU_SER_IDLE_GAP_EN` defined, C=0xFFFFFFFF, flags=4'b1001 -> one high bit between each of the 5 frames; 59-cycle response.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// ============================================================================
// Module : mtm_alu_pkg
// Brief  : Shared types and helpers for the MTM ALU serial link.
//          MTM_ALU_SER_IDLE_GAP_EN adds the GAP state to ser_state_t.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mtm_alu_pkg;

    localparam logic FRAME_DATA  = 1'b0;
    localparam logic FRAME_CTL   = 1'b1;
    localparam int   FRAME_LEN   = 11;
    localparam int   CRC_IN_BITS = 37;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
`ifdef MTM_ALU_SER_IDLE_GAP_EN
        ,
        GAP  = 2'd2
`endif
    } ser_state_t;

    // CRC-3, x^3+x+1, zero seed, MSB first
    function automatic logic [2:0] crc3(input logic [CRC_IN_BITS-1:0] data);
        logic [2:0] crc;
        logic       fb;
        crc = 3'd0;
        for (int i = CRC_IN_BITS - 1; i >= 0; i--) begin
            fb  = crc[2] ^ data[i];
            crc = {crc[1], crc[0] ^ fb, fb};
        end
        return crc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mtm_alu_serializer_crc3.sv
// ============================================================================
// Module : mtm_alu_crc3
// Brief  : Combinational CRC-3 over the 37-bit {C, 1'b0, flags} word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mtm_alu_crc3
    import mtm_alu_pkg::*;
(
    input  logic [CRC_IN_BITS-1:0] data,
    output logic [2:0]             crc
);

    assign crc = crc3(data);

endmodule

`default_nettype wire

// File: rtl/mtm_alu_serializer.sv
// ============================================================================
// Module : mtm_alu_serializer
// Brief  : Framed bit-serial transmitter for MTM ALU results and error reports.
//          Define MTM_ALU_SER_IDLE_GAP_EN to insert one idle bit between frames.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int BYTE_BITS  = 8,
    parameter int DATA_BYTES = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            res_valid,
    output logic                            res_ready,
    input  logic [DATA_BYTES*BYTE_BITS-1:0] C,
    input  logic [3:0]                      flags,
    input  logic                            err,
    input  logic [5:0]                      err_flags,
    output logic                            sout,
    output logic                            busy
);

    localparam logic [2:0] CTL_FRAME_IDX = 3'(DATA_BYTES);
    localparam logic [3:0] LAST_BIT      = 4'(FRAME_LEN - 1);

    ser_state_t                      state_q, state_d;
    logic [2:0]                      byte_cnt_q, byte_cnt_d;
    logic [3:0]                      bit_cnt_q, bit_cnt_d;
    logic [DATA_BYTES*BYTE_BITS-1:0] c_q, c_d;
    logic [3:0]                      flags_q, flags_d;
    logic                            err_q, err_d;
    logic [5:0]                      err_flags_q, err_flags_d;
    logic [2:0]                      crc_q, crc_d;
    logic                            sout_q, sout_d;
    logic                            res_ready_q, res_ready_d;
    logic                            busy_q, busy_d;

    logic [2:0]           w_crc;
    logic                 w_type;
    logic [BYTE_BITS-1:0] w_payload;
    logic [FRAME_LEN-1:0] w_frame;
    logic [3:0]           w_next_idx;
    logic [2:0]           w_last_frame;

    mtm_alu_crc3 u_crc3 (
        .data ({C, 1'b0, flags}),
        .crc  (w_crc)
    );

    always_comb begin
        w_type    = FRAME_DATA;
        w_payload = BYTE_BITS'(c_q >> (BYTE_BITS * (DATA_BYTES - 1 - int'(byte_cnt_q))));
        if (err_q) begin
            // trailing bit evens out the ones count of the payload
            w_type    = FRAME_CTL;
            w_payload = {1'b1, err_flags_q, ^{1'b1, err_flags_q}};
        end else if (byte_cnt_q == CTL_FRAME_IDX) begin
            w_type    = FRAME_CTL;
            w_payload = {1'b0, flags_q, crc_q};
        end
    end

    assign w_frame      = {1'b0, w_type, w_payload, 1'b1};
    assign w_next_idx   = 4'(FRAME_LEN - 2) - bit_cnt_q;
    assign w_last_frame = err_q ? 3'd0 : CTL_FRAME_IDX;

    // sout_d is the bit for the next cycle, so the start bit lands right after the transfer edge
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        c_d         = c_q;
        flags_d     = flags_q;
        err_d       = err_q;
        err_flags_d = err_flags_q;
        crc_d       = crc_q;
        sout_d      = sout_q;
        res_ready_d = res_ready_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (res_valid && res_ready_q) begin
                    state_d     = SEND;
                    byte_cnt_d  = 3'd0;
                    bit_cnt_d   = 4'd0;
                    c_d         = C;
                    flags_d     = flags;
                    err_d       = err;
                    err_flags_d = err_flags;
                    crc_d       = w_crc;
                    sout_d      = 1'b0;
                    res_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            SEND: begin
                if (bit_cnt_q != LAST_BIT) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    sout_d    = w_frame[w_next_idx];
                end else if (byte_cnt_q == w_last_frame) begin
                    state_d     = IDLE;
                    byte_cnt_d  = 3'd0;
                    bit_cnt_d   = 4'd0;
                    sout_d      = 1'b1;
                    res_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
`ifdef MTM_ALU_SER_IDLE_GAP_EN
                    state_d = GAP;
                    sout_d  = 1'b1;
`else
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    bit_cnt_d  = 4'd0;
                    sout_d     = 1'b0;
`endif
                end
            end
`ifdef MTM_ALU_SER_IDLE_GAP_EN
            GAP: begin
                state_d    = SEND;
                byte_cnt_d = byte_cnt_q + 3'd1;
                bit_cnt_d  = 4'd0;
                sout_d     = 1'b0;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 3'd0;
            bit_cnt_q   <= 4'd0;
            c_q         <= '0;
            flags_q     <= 4'd0;
            err_q       <= 1'b0;
            err_flags_q <= 6'd0;
            crc_q       <= 3'd0;
            sout_q      <= 1'b1;
            res_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            c_q         <= c_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            err_flags_q <= err_flags_d;
            crc_q       <= crc_d;
            sout_q      <= sout_d;
            res_ready_q <= res_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign sout      = sout_q;
    assign res_ready = res_ready_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mtm_alu_serializer.sv
// ============================================================================
// Module : tb_mtm_alu_serializer
// Brief  : Directed self-checking bench for mtm_alu_serializer; honours
//          MTM_ALU_SER_IDLE_GAP_EN when building expected line streams.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mtm_alu_serializer;

`ifdef MTM_ALU_SER_IDLE_GAP_EN
    localparam int GAP_EN = 1;
`else
    localparam int GAP_EN = 0;
`endif
    localparam int NORM_LEN = 55 + 4 * GAP_EN;
    localparam int ERR_LEN  = 11;

    // Normal vectors with hand-computed CTL payloads {0, flags, crc}
    localparam logic [31:0] NC [3] = '{32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF};
    localparam logic [3:0]  NF [3] = '{4'b0000, 4'b0110, 4'b1001};
    localparam logic [7:0]  NP [3] = '{8'h02, 8'h37, 8'h4D};
    // Error vectors with hand-computed payloads {1, err_flags, parity}
    localparam logic [5:0]  EF [3] = '{6'b100100, 6'b000000, 6'b111111};
    localparam logic [7:0]  EP [3] = '{8'hC9, 8'h81, 8'hFF};

    logic        clk;
    logic        reset_n;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] C;
    logic [3:0]  flags;
    logic        err;
    logic [5:0]  err_flags;
    logic        sout;
    logic        busy;

    int vectors;
    int miscompares;

    mtm_alu_serializer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .C         (C),
        .flags     (flags),
        .err       (err),
        .err_flags (err_flags),
        .sout      (sout),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Expected sout per cycle after the transfer edge; bit i is cycle T+1+i
    function automatic logic [63:0] exp_stream(input logic [31:0] c, input logic is_err,
                                               input logic [7:0] ctl);
        logic [63:0] s;
        logic [10:0] fw;
        int          pos;
        int          nfr;
        s   = '1;
        pos = 0;
        nfr = is_err ? 1 : 5;
        for (int f = 0; f < nfr; f++) begin
            if (f == nfr - 1) fw = {1'b0, 1'b1, ctl, 1'b1};
            else              fw = {1'b0, 1'b0, c[31-8*f -: 8], 1'b1};
            for (int b = 0; b < 11; b++) begin
                s[pos] = fw[10-b];
                pos++;
            end
            if (GAP_EN == 1 && f != nfr - 1) begin
                s[pos] = 1'b1;
                pos++;
            end
        end
        return s;
    endfunction

    task automatic present(input logic [31:0] c, input logic [3:0] f, input logic e,
                           input logic [5:0] ef);
        @(negedge clk);
        C         = c;
        flags     = f;
        err       = e;
        err_flags = ef;
        res_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        res_valid = 1'b0;
        C         = 32'h0;
        flags     = 4'h0;
        err       = 1'b0;
        err_flags = 6'h0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({sout, busy, res_ready} !== 3'b101) begin
            miscompares++;
            $display("FAIL reset_hold: got sout/busy/ready=%b%b%b want 101", sout, busy, res_ready);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if ({sout, busy, res_ready} !== 3'b101) begin
                miscompares++;
                $display("FAIL reset_idle cyc%0d: got sout/busy/ready=%b%b%b want 101",
                         i, sout, busy, res_ready);
            end
        end
    endtask

    task automatic test_normal();
        logic [63:0] eb;
        for (int v = 0; v < 3; v++) begin
            eb = exp_stream(NC[v], 1'b0, NP[v]);
            present(NC[v], NF[v], 1'b0, 6'h2A);
            vectors++;
            if (res_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL normal%0d ready: got %b want 1", v, res_ready);
            end
            @(posedge clk);
            for (int i = 0; i < NORM_LEN; i++) begin
                @(negedge clk);
                if (i == 0) begin
                    res_valid = 1'b1; C = 'x; flags = 'x; err = 1'bx; err_flags = 'x;
                end
                if (i == 3) begin
                    res_valid = 1'b0; C = ~NC[v]; flags = ~NF[v]; err = 1'b1; err_flags = 6'h15;
                end
                vectors++;
                if ({sout, busy, res_ready} !== {eb[i], 2'b10}) begin
                    miscompares++;
                    $display("FAIL normal%0d bit%0d: got sout/busy/ready=%b%b%b want %b10",
                             v, i, sout, busy, res_ready, eb[i]);
                end
            end
            @(negedge clk);
            vectors++;
            if ({sout, busy, res_ready} !== 3'b101) begin
                miscompares++;
                $display("FAIL normal%0d end: got sout/busy/ready=%b%b%b want 101",
                         v, sout, busy, res_ready);
            end
        end
    endtask

    task automatic test_error();
        logic [63:0] eb;
        for (int v = 0; v < 3; v++) begin
            eb = exp_stream(32'h0, 1'b1, EP[v]);
            present(32'hFFFF_FFFF, 4'hF, 1'b1, EF[v]);
            @(posedge clk);
            for (int i = 0; i < ERR_LEN; i++) begin
                @(negedge clk);
                if (i == 0) begin
                    res_valid = 1'b0; err = 1'b0; err_flags = ~EF[v];
                end
                vectors++;
                if ({sout, busy, res_ready} !== {eb[i], 2'b10}) begin
                    miscompares++;
                    $display("FAIL error%0d bit%0d: got sout/busy/ready=%b%b%b want %b10",
                             v, i, sout, busy, res_ready, eb[i]);
                end
            end
            @(negedge clk);
            vectors++;
            if ({sout, busy, res_ready} !== 3'b101) begin
                miscompares++;
                $display("FAIL error%0d end: got sout/busy/ready=%b%b%b want 101",
                         v, sout, busy, res_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ea;
        logic [63:0] eb;
        ea = exp_stream(NC[1], 1'b0, NP[1]);
        eb = exp_stream(32'h0, 1'b1, EP[0]);
        present(NC[1], NF[1], 1'b0, 6'h00);
        @(posedge clk);
        for (int i = 0; i < NORM_LEN; i++) begin
            @(negedge clk);
            if (i == 0) begin
                C = 32'h0; flags = 4'h0; err = 1'b1; err_flags = EF[0];
            end
            vectors++;
            if ({sout, busy, res_ready} !== {ea[i], 2'b10}) begin
                miscompares++;
                $display("FAIL b2b_first bit%0d: got sout/busy/ready=%b%b%b want %b10",
                         i, sout, busy, res_ready, ea[i]);
            end
        end
        @(negedge clk);
        vectors++;
        if ({sout, busy, res_ready} !== 3'b101) begin
            miscompares++;
            $display("FAIL b2b_gap: got sout/busy/ready=%b%b%b want 101", sout, busy, res_ready);
        end
        @(posedge clk);
        for (int i = 0; i < ERR_LEN; i++) begin
            @(negedge clk);
            if (i == 0) res_valid = 1'b0;
            vectors++;
            if ({sout, busy, res_ready} !== {eb[i], 2'b10}) begin
                miscompares++;
                $display("FAIL b2b_second bit%0d: got sout/busy/ready=%b%b%b want %b10",
                         i, sout, busy, res_ready, eb[i]);
            end
        end
        @(negedge clk);
        vectors++;
        if ({sout, busy, res_ready} !== 3'b101) begin
            miscompares++;
            $display("FAIL b2b_end: got sout/busy/ready=%b%b%b want 101", sout, busy, res_ready);
        end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] ea;
        logic [63:0] eb;
        ea = exp_stream(NC[1], 1'b0, NP[1]);
        eb = exp_stream(NC[2], 1'b0, NP[2]);
        present(NC[1], NF[1], 1'b0, 6'h00);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) res_valid = 1'b0;
            vectors++;
            if ({sout, busy, res_ready} !== {ea[i], 2'b10}) begin
                miscompares++;
                $display("FAIL midrst_pre bit%0d: got sout/busy/ready=%b%b%b want %b10",
                         i, sout, busy, res_ready, ea[i]);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({sout, busy, res_ready} !== 3'b101) begin
            miscompares++;
            $display("FAIL midrst_async: got sout/busy/ready=%b%b%b want 101", sout, busy, res_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({sout, busy, res_ready} !== 3'b101) begin
                miscompares++;
                $display("FAIL midrst_idle cyc%0d: got sout/busy/ready=%b%b%b want 101",
                         i, sout, busy, res_ready);
            end
        end
        present(NC[2], NF[2], 1'b0, 6'h00);
        @(posedge clk);
        for (int i = 0; i < NORM_LEN; i++) begin
            @(negedge clk);
            if (i == 0) res_valid = 1'b0;
            vectors++;
            if ({sout, busy, res_ready} !== {eb[i], 2'b10}) begin
                miscompares++;
                $display("FAIL midrst_post bit%0d: got sout/busy/ready=%b%b%b want %b10",
                         i, sout, busy, res_ready, eb[i]);
            end
        end
        @(negedge clk);
        vectors++;
        if ({sout, busy, res_ready} !== 3'b101) begin
            miscompares++;
            $display("FAIL midrst_end: got sout/busy/ready=%b%b%b want 101", sout, busy, res_ready);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_normal();
        test_error();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
